// File: rtl/painterengine_gpu_pkg.sv
// rtl/painterengine_gpu_pkg.sv - shared types and widths for the GPU writer feeder slice.
package painterengine_gpu_pkg;

  localparam int LEN_W      = 32;
  localparam int UNDERRUN_W = 16;

  typedef enum logic [1:0] {
    FEEDER_IDLE  = 2'd0,
    FEEDER_RUN   = 2'd1,
    FEEDER_DRAIN = 2'd2,
    FEEDER_DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/painterengine_gpu_sync_fifo.sv
// rtl/painterengine_gpu_sync_fifo.sv - first-word-fall-through synchronous FIFO with flush.
module painterengine_gpu_sync_fifo #(
  parameter int PARAM_DATA_WIDTH = 32,
  parameter int PARAM_FIFO_DEPTH = 16
) (
  input  logic                              i_wire_clock,
  input  logic                              i_wire_reset,
  input  logic                              i_wire_flush,
  input  logic                              i_wire_push,
  input  logic [PARAM_DATA_WIDTH-1:0]       i_wire_push_data,
  input  logic                              i_wire_pop,
  output logic [PARAM_DATA_WIDTH-1:0]       o_wire_head_data,
  output logic                              o_wire_full,
  output logic                              o_wire_empty,
  output logic [$clog2(PARAM_FIFO_DEPTH):0] o_wire_level
);

  localparam int ADDR_W = $clog2(PARAM_FIFO_DEPTH);

  logic [PARAM_DATA_WIDTH-1:0] mem [PARAM_FIFO_DEPTH];
  logic [ADDR_W:0]             wr_ptr;
  logic [ADDR_W:0]             rd_ptr;
  logic                        wr_en;
  logic                        rd_en;

  // Pointers carry one extra MSB so equal low bits with differing MSB means full.
  assign o_wire_level     = wr_ptr - rd_ptr;
  assign o_wire_empty     = (wr_ptr == rd_ptr);
  assign o_wire_full      = (o_wire_level == (ADDR_W+1)'(PARAM_FIFO_DEPTH));
  assign o_wire_head_data = mem[rd_ptr[ADDR_W-1:0]];

  assign wr_en = i_wire_push && !o_wire_full && !i_wire_flush;
  assign rd_en = i_wire_pop && !o_wire_empty && !i_wire_flush;

  always_ff @(posedge i_wire_clock) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= i_wire_push_data;
    end
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset || i_wire_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/painterengine_gpu_writer_feeder.sv
// rtl/painterengine_gpu_writer_feeder.sv - FIFO-backed job feeder for one GPU DMA writer lane.
// Optional starvation counter enabled by PAINTERENGINE_GPU_FEEDER_UNDERRUN_EN.
module painterengine_gpu_writer_feeder
  import painterengine_gpu_pkg::*;
#(
  parameter int PARAM_DATA_WIDTH = 32,
  parameter int PARAM_FIFO_DEPTH = 16
) (
  input  logic                              i_wire_clock,
  input  logic                              i_wire_reset,
  input  logic                              i_wire_start,
  input  logic [LEN_W-1:0]                  i_wire_length,
  input  logic [PARAM_DATA_WIDTH-1:0]       i_wire_push_data,
  input  logic                              i_wire_push_valid,
  output logic                              o_wire_push_ready,
  output logic [PARAM_DATA_WIDTH-1:0]       o_wire_data,
  output logic                              o_wire_data_valid,
  input  logic                              i_wire_data_next,
  output logic [$clog2(PARAM_FIFO_DEPTH):0] o_wire_level,
  output logic                              o_wire_busy,
  output logic                              o_wire_done,
  output logic [UNDERRUN_W-1:0]             o_wire_underrun_count
);

  feeder_state_t               state;
  logic [LEN_W-1:0]            length_reg;
  logic [LEN_W-1:0]            pushed_count;
  logic [LEN_W-1:0]            popped_count;
  logic [PARAM_DATA_WIDTH-1:0] head_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push_fire;
  logic                        pop_fire;
  logic                        last_push;
  logic                        last_pop;

  assign o_wire_push_ready = (state == FEEDER_RUN) && !fifo_full && (pushed_count < length_reg);
  assign o_wire_data_valid = !fifo_empty && ((state == FEEDER_RUN) || (state == FEEDER_DRAIN));
  assign o_wire_data       = o_wire_data_valid ? head_data : '0;
  assign o_wire_busy       = (state == FEEDER_RUN) || (state == FEEDER_DRAIN);
  assign o_wire_done       = (state == FEEDER_DONE);

  // A start pulse wins over any handshake on the same edge.
  assign push_fire = i_wire_push_valid && o_wire_push_ready && !i_wire_start;
  assign pop_fire  = i_wire_data_next && o_wire_data_valid && !i_wire_start;
  assign last_push = push_fire && (pushed_count == length_reg - 1'b1);
  assign last_pop  = pop_fire && (popped_count == length_reg - 1'b1);

  painterengine_gpu_sync_fifo #(
    .PARAM_DATA_WIDTH (PARAM_DATA_WIDTH),
    .PARAM_FIFO_DEPTH (PARAM_FIFO_DEPTH)
  ) u_fifo (
    .i_wire_clock     (i_wire_clock),
    .i_wire_reset     (i_wire_reset),
    .i_wire_flush     (i_wire_start),
    .i_wire_push      (push_fire),
    .i_wire_push_data (i_wire_push_data),
    .i_wire_pop       (pop_fire),
    .o_wire_head_data (head_data),
    .o_wire_full      (fifo_full),
    .o_wire_empty     (fifo_empty),
    .o_wire_level     (o_wire_level)
  );

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state        <= FEEDER_IDLE;
      length_reg   <= '0;
      pushed_count <= '0;
      popped_count <= '0;
    end else if (i_wire_start) begin
      length_reg   <= i_wire_length;
      pushed_count <= '0;
      popped_count <= '0;
      state        <= (i_wire_length == '0) ? FEEDER_DONE : FEEDER_RUN;
    end else begin
      if (push_fire) pushed_count <= pushed_count + 1'b1;
      if (pop_fire)  popped_count <= popped_count + 1'b1;
      case (state)
        FEEDER_RUN: begin
          if (last_pop)       state <= FEEDER_DONE;
          else if (last_push) state <= FEEDER_DRAIN;
        end
        FEEDER_DRAIN: begin
          if (last_pop) state <= FEEDER_DONE;
        end
        default: state <= state;
      endcase
    end
  end

`ifdef PAINTERENGINE_GPU_FEEDER_UNDERRUN_EN
  logic [UNDERRUN_W-1:0] underrun_count;

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset || i_wire_start) begin
      underrun_count <= '0;
    end else if ((state == FEEDER_RUN) && fifo_empty && (underrun_count != '1)) begin
      underrun_count <= underrun_count + 1'b1;
    end
  end

  assign o_wire_underrun_count = underrun_count;
`else
  assign o_wire_underrun_count = '0;
`endif

endmodule

// File: tb/tb_painterengine_gpu_writer_feeder.sv
// tb/tb_painterengine_gpu_writer_feeder.sv - directed self-checking bench for the writer feeder.
module tb_painterengine_gpu_writer_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] length = '0;
  logic [31:0] push_data = '0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] data;
  logic        data_valid;
  logic        data_next = 1'b0;
  logic [4:0]  level;
  logic        busy;
  logic        done;
  logic [15:0] underrun;

  int test_count = 0;
  int fail_count = 0;
  int sent;
  int rd;

  painterengine_gpu_writer_feeder #(
    .PARAM_DATA_WIDTH (32),
    .PARAM_FIFO_DEPTH (16)
  ) dut (
    .i_wire_clock          (clk),
    .i_wire_reset          (rst),
    .i_wire_start          (start),
    .i_wire_length         (length),
    .i_wire_push_data      (push_data),
    .i_wire_push_valid     (push_valid),
    .o_wire_push_ready     (push_ready),
    .o_wire_data           (data),
    .o_wire_data_valid     (data_valid),
    .i_wire_data_next      (data_next),
    .o_wire_level          (level),
    .o_wire_busy           (busy),
    .o_wire_done           (done),
    .o_wire_underrun_count (underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] len);
    start  = 1'b1;
    length = len;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [4];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    expect_eq("rst_valid", 32'(data_valid), 0);
    expect_eq("rst_level", 32'(level), 0);
    expect_eq("rst_busy", 32'(busy), 0);
    expect_eq("rst_done", 32'(done), 0);
    expect_eq("rst_ready", 32'(push_ready), 0);
    expect_eq("rst_data", data, 0);
    expect_eq("rst_underrun", 32'(underrun), 0);

    // Basic flow, length 4
    start_job(4);
    expect_eq("basic_busy", 32'(busy), 1);
    push_valid = 1'b1;
    data_next  = 1'b1;
    expect_eq("basic_ready0", 32'(push_ready), 1);
    expect_eq("basic_valid0", 32'(data_valid), 0);
    for (int i = 0; i < 4; i++) begin
      push_data = w[i];
      tick();
      expect_eq("basic_valid", 32'(data_valid), 1);
      expect_eq("basic_data", data, w[i]);
    end
    expect_eq("basic_ready_end", 32'(push_ready), 0);
    expect_eq("basic_not_done", 32'(done), 0);
    push_valid = 1'b0;
    tick();
    expect_eq("basic_done", 32'(done), 1);
    expect_eq("basic_level", 32'(level), 0);
    data_next = 1'b0;

    // Full FIFO, length 20
    start_job(20);
    push_valid = 1'b1;
    sent = 0;
    push_data = 32'h100;
    for (int c = 0; c < 40 && sent < 16; c++) begin
      if (push_ready) sent++;
      tick();
      push_data = 32'h100 + 32'(sent);
    end
    expect_eq("full_level", 32'(level), 16);
    expect_eq("full_ready", 32'(push_ready), 0);
    tick(); tick(); tick();
    expect_eq("full_hold_level", 32'(level), 16);
    data_next = 1'b1;
    rd = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (data_valid) begin
        expect_eq("full_order", data, 32'h100 + 32'(rd));
        rd++;
      end
      if (push_ready && push_valid) sent++;
      tick();
      push_data = 32'h100 + 32'(sent);
      if (sent == 20) push_valid = 1'b0;
    end
    expect_eq("full_done", 32'(done), 1);
    expect_eq("full_rd_count", 32'(rd), 20);
    expect_eq("full_sent_count", 32'(sent), 20);
    push_valid = 1'b0;
    data_next  = 1'b0;

    // Simultaneous push and pop at level 1
    start_job(9);
    push_valid = 1'b1;
    push_data  = 32'hA0;
    tick();
    expect_eq("sim_level_init", 32'(level), 1);
    data_next = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push_data = 32'hA0 + 32'(i);
      expect_eq("sim_head", data, 32'hA0 + 32'(i - 1));
      tick();
      expect_eq("sim_level", 32'(level), 1);
    end
    push_valid = 1'b0;
    expect_eq("sim_last", data, 32'hA8);
    tick();
    expect_eq("sim_done", 32'(done), 1);
    data_next = 1'b0;

    // Abort mid-job
    start_job(8);
    push_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_data = 32'hB0 + 32'(i);
      tick();
    end
    push_valid = 1'b0;
    expect_eq("abort_level3", 32'(level), 3);
    data_next = 1'b1;
    tick();
    data_next = 1'b0;
    expect_eq("abort_level2", 32'(level), 2);
    start_job(2);
    expect_eq("abort_flush_level", 32'(level), 0);
    expect_eq("abort_flush_valid", 32'(data_valid), 0);
    push_valid = 1'b1;
    data_next  = 1'b1;
    push_data  = 32'hC0;
    tick();
    expect_eq("abort_new0", data, 32'hC0);
    push_data = 32'hC1;
    tick();
    expect_eq("abort_new1", data, 32'hC1);
    expect_eq("abort_ready_end", 32'(push_ready), 0);
    push_valid = 1'b0;
    tick();
    expect_eq("abort_done", 32'(done), 1);
    data_next = 1'b0;

    // Zero length
    start_job(0);
    expect_eq("zero_done", 32'(done), 1);
    expect_eq("zero_ready", 32'(push_ready), 0);
    push_valid = 1'b1;
    data_next  = 1'b1;
    push_data  = 32'hEE;
    tick();
    push_valid = 1'b0;
    data_next  = 1'b0;
    expect_eq("zero_level", 32'(level), 0);
    expect_eq("zero_valid", 32'(data_valid), 0);
    expect_eq("zero_hold_done", 32'(done), 1);

    // Reset mid-job
    start_job(5);
    push_valid = 1'b1;
    push_data  = 32'hD0;
    tick();
    push_data  = 32'hD1;
    tick();
    push_valid = 1'b0;
    expect_eq("rstmid_level2", 32'(level), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_eq("rstmid_level", 32'(level), 0);
    expect_eq("rstmid_busy", 32'(busy), 0);
    expect_eq("rstmid_valid", 32'(data_valid), 0);

    // Underrun: first push issued 10 cycles after the start cycle
    start_job(4);
    for (int i = 0; i < 9; i++) tick();
    push_valid = 1'b1;
    data_next  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_data = w[i];
      tick();
      expect_eq("und_data", data, w[i]);
    end
    push_valid = 1'b0;
    tick();
    data_next = 1'b0;
    expect_eq("und_done", 32'(done), 1);
`ifdef PAINTERENGINE_GPU_FEEDER_UNDERRUN_EN
    expect_eq("und_count", 32'(underrun), 10);
`else
    expect_eq("und_count", 32'(underrun), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
